// File: rtl/audio_clk_pkg.sv
// audio_clk_pkg: shared enums and width helpers for the audio clock generator
package audio_clk_pkg;
  typedef enum logic {FS_I2S = 1'b0, FS_TDM = 1'b1} fs_mode_e;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} clkgen_state_e;
  localparam int DIV_CFG_W = 8;
  function automatic int width_of(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clk_en_divider.sv
// clk_en_divider: toggle divider that flips level every half-period of enabled counts
module clk_en_divider #(
  parameter int W = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         cnt_en,
  input  logic [W-1:0] half,
  output logic         level,
  output logic         rise_evt,
  output logic         fall_evt
);
  logic [W-1:0] cnt;
  logic tick;
  assign tick = cnt_en && cnt >= half - 1'b1;
  assign rise_evt = tick && !level;
  assign fall_evt = tick && level;
  // Half-period counter; >= keeps it safe if half shrinks mid-count
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      cnt <= '0;
      level <= 1'b0;
    end else if (cnt_en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      level <= level ^ tick;
    end
endmodule

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: I2S/TDM clock master on sys_clk enables; I2S_CLKGEN_RUNTIME_DIV_EN adds a runtime MCLK divider input
module i2s_clock_gen
  import audio_clk_pkg::*;
#(
  parameter int MCLK_DIV  = 6,
  parameter int BCK_RATIO = 4,
  parameter int SLOT_BITS = 32,
  parameter int NUM_SLOTS = 2,
  parameter int FS_MODE   = 0
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         enable,
`ifdef I2S_CLKGEN_RUNTIME_DIV_EN
  input  logic [DIV_CFG_W-1:0]         mclk_div_cfg,
`endif
  output logic                         mclk,
  output logic                         bck,
  output logic                         lrck,
  output logic                         bck_rise_stb,
  output logic                         bck_fall_stb,
  output logic                         frame_start_stb,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
  output logic                         running
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int BW = $clog2(SLOT_BITS);
  localparam int RW = width_of(BCK_RATIO / 2 + 1);
  localparam fs_mode_e MODE = (FS_MODE == 1) ? FS_TDM : FS_I2S;
  if (MCLK_DIV < 2 || MCLK_DIV % 2 != 0) begin : g_chk_mclk
    $error("i2s_clock_gen: MCLK_DIV must be even and >= 2");
  end
  if (BCK_RATIO < 2 || BCK_RATIO % 2 != 0) begin : g_chk_bck
    $error("i2s_clock_gen: BCK_RATIO must be even and >= 2");
  end
  if (SLOT_BITS < 8 || NUM_SLOTS < 2 || FS_MODE < 0 || FS_MODE > 1) begin : g_chk_frame
    $error("i2s_clock_gen: need SLOT_BITS >= 8, NUM_SLOTS >= 2, FS_MODE 0 or 1");
  end
  if (FS_MODE == 0 && NUM_SLOTS != 2) begin : g_chk_i2s
    $error("i2s_clock_gen: I2S mode requires NUM_SLOTS == 2");
  end
  clkgen_state_e state;
  logic mclk_rise, mclk_fall_unused, bck_rise, bck_fall;
  logic bit_wrap, frame_wrap, stop, lrck_nxt;
  logic [BW-1:0] bit_nxt;
  logic [SW-1:0] slot_nxt;
  assign bit_wrap = bit_idx == BW'(SLOT_BITS - 1);
  assign frame_wrap = bit_wrap && slot_idx == SW'(NUM_SLOTS - 1);
  assign bit_nxt = bit_wrap ? '0 : bit_idx + 1'b1;
  assign slot_nxt = bit_wrap ? (frame_wrap ? '0 : slot_idx + 1'b1) : slot_idx;
  assign lrck_nxt = MODE == FS_TDM ? (slot_nxt == '0 && bit_nxt == '0) : (slot_nxt >= SW'(NUM_SLOTS / 2));
  assign stop = bck_fall && frame_wrap && state == STOPPING && !enable;
`ifdef I2S_CLKGEN_RUNTIME_DIV_EN
  localparam int MW = DIV_CFG_W;
  logic [MW-1:0] mclk_half;
  // Shadow divider only reloads while idle or at a frame boundary, never mid-frame
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst)
      mclk_half <= MW'(MCLK_DIV / 2);
    else if (state == IDLE || (bck_fall && frame_wrap))
      mclk_half <= mclk_div_cfg < 2 ? MW'(1) : {1'b0, mclk_div_cfg[DIV_CFG_W-1:1]};
`else
  localparam int MW = width_of(MCLK_DIV / 2 + 1);
  logic [MW-1:0] mclk_half;
  assign mclk_half = MW'(MCLK_DIV / 2);
`endif
  clk_en_divider #(.W(MW)) u_mclk_div (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cnt_en  (1'b1),
    .half    (mclk_half),
    .level   (mclk),
    .rise_evt(mclk_rise),
    .fall_evt(mclk_fall_unused)
  );
  clk_en_divider #(.W(RW)) u_bck_div (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cnt_en  (mclk_rise && state != IDLE),
    .half    (RW'(BCK_RATIO / 2)),
    .level   (bck),
    .rise_evt(bck_rise),
    .fall_evt(bck_fall)
  );
  // Frame FSM: start on an MCLK rise, advance slot/bit/lrck on BCK falls, stop only at frame wrap
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= IDLE;
      running <= 1'b0;
      lrck <= 1'b0;
      slot_idx <= '0;
      bit_idx <= '0;
      bck_rise_stb <= 1'b0;
      bck_fall_stb <= 1'b0;
      frame_start_stb <= 1'b0;
    end else begin
      bck_rise_stb <= bck_rise;
      bck_fall_stb <= bck_fall;
      frame_start_stb <= 1'b0;
      if (state == IDLE) begin
        if (enable && mclk_rise) begin
          state <= RUN;
          running <= 1'b1;
          frame_start_stb <= 1'b1;
          lrck <= MODE == FS_TDM;
        end
      end else if (stop) begin
        state <= IDLE;
        running <= 1'b0;
        lrck <= 1'b0;
        slot_idx <= '0;
        bit_idx <= '0;
      end else begin
        state <= enable ? RUN : STOPPING;
        if (bck_fall) begin
          slot_idx <= slot_nxt;
          bit_idx <= bit_nxt;
          lrck <= lrck_nxt;
          frame_start_stb <= frame_wrap;
        end
      end
    end
endmodule

// File: doc/i2s_clock_gen.md
Name: i2s_clock_gen

Overview:
- Parametrised I2S/TDM clock master. Replaces the hard-wired MCLK/BCK/LRCK divide-by-6/4/64 chain in the upscaler top.
- Derives MCLK, BCK and frame sync from sys_clk using clock-enable counters. It does not create derived clock domains.
- Exposes bit/slot position and edge strobes so that i2s_rx and future TDM receivers can run on sys_clk.
- Supports stereo I2S and multi-slot TDM. Stops and starts cleanly only on frame boundaries.

Parameters:
- MCLK_DIV, 6: sys_clk cycles per MCLK period. Even, >=2.
- BCK_RATIO, 4: MCLK periods per BCK period. Even, >=2.
- SLOT_BITS, 32: BCK periods per slot. >=8.
- NUM_SLOTS, 2: slots per frame. >=2. Must be 2 when FS_MODE=0.
- FS_MODE, 0: 0 = I2S 50%-duty LRCK; 1 = TDM one-BCK frame-sync pulse.

Ports:
- sys_clk in 1: system clock.
- sys_rst in 1: reset, asynchronous, active-high.
- enable in 1: request to run.
- mclk out 1: master clock, 50% duty.
- bck out 1: bit clock, 50% duty.
- lrck out 1: word select / frame sync.
- bck_rise_stb out 1: one-cycle pulse; BCK has just risen (receiver sample point).
- bck_fall_stb out 1: one-cycle pulse; BCK has just fallen (data launch point).
- frame_start_stb out 1: one-cycle pulse at start of slot 0, bit 0.
- slot_idx out $clog2(NUM_SLOTS): current slot.
- bit_idx out $clog2(SLOT_BITS): current bit within slot, MSB-first count.
- running out 1: clocks active.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE.
- MCLK divider: mclk toggles when mcnt reaches MCLK_DIV/2-1, then mcnt wraps to 0. mclk runs whenever not in reset, independent of enable, because the ADC needs MCLK to settle.
- mclk_rise event: the cycle in which mclk toggles 0->1.
- BCK divider: counts mclk_rise events only in RUN. When bcnt reaches BCK_RATIO/2-1, bck toggles. BCK period = MCLK_DIV*BCK_RATIO sys_clk cycles.
- Strobes are registered with bck. Each is high for the first sys_clk cycle in which the new bck level is visible.
- On every BCK fall:
  - bit_idx increments; wraps at SLOT_BITS-1.
  - On wrap, slot_idx increments; wraps at NUM_SLOTS-1.
  - On wrap to slot 0/bit 0, frame_start_stb pulses.
- lrck, FS_MODE=0: lrck = (slot_idx >= NUM_SLOTS/2). Low = left. It changes only coincident with a BCK fall.
- lrck, FS_MODE=1: lrck high exactly while slot_idx==0 and bit_idx==0, otherwise low.
- Sample rate: f_sys/(MCLK_DIV*BCK_RATIO*SLOT_BITS*NUM_SLOTS). Defaults at 74.25 MHz give 48.34 kHz.
- FSM IDLE:
  - bck=0, lrck=0, counters 0, running=0.
  - If enable=1 at an mclk_rise event, go to RUN: running<=1, frame_start_stb pulses, slot 0/bit 0 current.
  - First BCK rise occurs BCK_RATIO/2 mclk rises later.
- FSM RUN:
  - If enable=0 is seen, go to STOPPING.
- FSM STOPPING:
  - Continues normally until the BCK fall that would wrap to slot 0/bit 0.
  - At that fall: bck=0, lrck=0, counters 0, running<=0, no frame_start_stb, go to IDLE.
  - If enable returns to 1 before the wrap, go back to RUN; no gap, frame continues.
- Partial frames are never emitted.
- sys_rst mid-frame: immediate asynchronous return to reset values. No completion of the frame.
- Parameter legality is checked with elaboration-time $error: odd dividers; NUM_SLOTS!=2 with FS_MODE=0.

Optional Feature:
- Macro: I2S_CLKGEN_RUNTIME_DIV_EN.
- With the macro:
  - Adds input mclk_div_cfg [7:0], used in place of MCLK_DIV.
  - Sampled into a shadow register only while IDLE or at the frame-wrap BCK fall, so a change never shortens a frame mid-way.
  - Odd values round down. Values <2 clamp to 2.
- Without the macro: the port is absent and MCLK_DIV is constant.

Decomposition:
- Package audio_clk_pkg:
  - fs_mode_e enum (FS_I2S, FS_TDM).
  - clkgen_state_e enum (IDLE, RUN, STOPPING).
  - Width helper constants.
- Sub-module clk_en_divider: generic toggle divider.
  - Inputs: count enable, half-period.
  - Outputs: level, rise_evt, fall_evt.
  - Instantiated twice, once for MCLK and once for BCK.
- Frame counters and FSM stay in i2s_clock_gen.

Test Plan:
- Defaults, enable=1 after reset -> mclk period 6 cycles, bck period 24 cycles, lrck period 1536 cycles, lrck high for 768, all edges 50% duty.
- FS_MODE=1, NUM_SLOTS=8, SLOT_BITS=32 -> lrck high for exactly 24 cycles once per 6144 cycles; slot_idx steps 0..7; frame_start_stb coincides with lrck rise.
- enable dropped at slot 1 bit 5 -> clocks continue to frame end, then bck/lrck held 0 and running=0; mclk keeps toggling; restart begins at slot 0 bit 0.
- enable pulsed low for 10 cycles mid-frame -> no stop, no missing BCK edge, bit_idx continuous.
- sys_rst asserted mid-slot -> same cycle all outputs 0; after release mclk restarts from mcnt=0.
- With I2S_CLKGEN_RUNTIME_DIV_EN, cfg changed 6->8 mid-frame -> current frame keeps 6; next frame mclk period 8; cfg=1 -> period 2.
